// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is data priority with a streak limit.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ready,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 0 = fetch, 1 = data
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                if_ready_q, if_ready_d;
  logic                if_err_q, if_err_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                d_ready_q, d_ready_d;
  logic                d_err_q, d_err_d;
  logic [63:0]         d_rdata_q, d_rdata_d;
  logic                gnt_data, gnt_fetch;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // owner_q is updated on every grant, so it doubles as the last-owner register.
  always_comb begin
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    if (if_req && d_req) begin
      gnt_data  = ~owner_q;
      gnt_fetch = owner_q;
    end else begin
      gnt_data  = d_req;
      gnt_fetch = if_req;
    end
  end
`else
  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

  logic [StreakW-1:0] streak_q, streak_d;

  always_comb begin
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    if (if_req && d_req) begin
      gnt_fetch = (streak_q == StreakMax);
      gnt_data  = ~gnt_fetch;
    end else begin
      gnt_data  = d_req;
      gnt_fetch = if_req;
    end
  end

  // Streak only advances while fetch is being starved.
  always_comb begin
    streak_d = streak_q;
    if (state_q == StIdle) begin
      if (gnt_data && if_req) begin
        streak_d = streak_q + StreakW'(1);
      end else if (gnt_data || gnt_fetch) begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tmo_d       = tmo_q;
    if_ready_d  = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      StIdle: begin
        if (gnt_data || gnt_fetch) begin
          state_d   = StBusy;
          mem_req_d = 1'b1;
          tmo_d     = '0;
          owner_d   = gnt_data;
          if (gnt_data) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (owner_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else if (tmo_q == TmoLast) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (owner_q) begin
            d_ready_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ready_d = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tmo_q       <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tmo_q       <= tmo_d;
      if_ready_q  <= if_ready_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [31:0]   if_rdata;
  logic          if_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic          d_ready;
  logic [63:0]   d_rdata;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          mem_ack;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (16),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // Requester protocol monitors: request and address must hold until ready.
  logic          if_pend = 1'b0;
  logic [AW-1:0] if_addr_h;
  logic          d_pend = 1'b0;
  logic [AW-1:0] d_addr_h;

  always @(negedge clk) begin
    if (reset) begin
      if_pend = 1'b0;
      d_pend  = 1'b0;
    end else begin
      if (if_ready) begin
        if_pend = 1'b0;
      end else if (if_pend) begin
        check_eq("if_hold", 64'(if_req && (if_addr == if_addr_h)), 64'd1);
      end else if (if_req) begin
        if_pend   = 1'b1;
        if_addr_h = if_addr;
      end
      if (d_ready) begin
        d_pend = 1'b0;
      end else if (d_pend) begin
        check_eq("d_hold", 64'(d_req && (d_addr == d_addr_h)), 64'd1);
      end else if (d_req) begin
        d_pend   = 1'b1;
        d_addr_h = d_addr;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] got_g [6];
    logic [7:0] exp_g [6];
    int         ng;
    int         cnt;
    int         rdy_at;
    logic       seen;
    logic       stable;
    logic       err_s;
    logic [63:0] rdata_s;

    // Reset state
    do_reset();
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    check_eq("rst_mem_wdata", mem_wdata, 64'd0);
    check_eq("rst_readys", 64'({if_ready, d_ready, if_err, d_err}), 64'd0);
    check_eq("rst_rdata", 64'(if_rdata) | d_rdata, 64'd0);

    // Fetch only
    if_req  = 1'b1;
    if_addr = 64'h4;
    step();
    check_eq("f_mem_req", 64'(mem_req), 64'd1);
    check_eq("f_mem_addr", mem_addr, 64'h4);
    check_eq("f_mem_we", 64'(mem_we), 64'd0);
    check_eq("f_no_early_rdy", 64'(if_ready), 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEADBEEF_00A00093;
    step();
    check_eq("f_ready", 64'(if_ready), 64'd1);
    check_eq("f_rdata", 64'(if_rdata), 64'hDEADBEEF);
    check_eq("f_err", 64'(if_err), 64'd0);
    check_eq("f_mem_req_drop", 64'(mem_req), 64'd0);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    step();
    check_eq("f_ready_pulse", 64'(if_ready), 64'd0);

    // Store then load
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h100;
    d_wdata = 64'h1234;
    step();
    check_eq("st_mem_req", 64'(mem_req), 64'd1);
    check_eq("st_mem_we", 64'(mem_we), 64'd1);
    check_eq("st_mem_wdata", mem_wdata, 64'h1234);
    mem_ack   = 1'b1;
    mem_rdata = 64'h0;
    step();
    check_eq("st_ready", 64'(d_ready), 64'd1);
    mem_ack = 1'b0;
    d_we    = 1'b0;
    d_wdata = 64'h0;
    step();
    check_eq("ld_idle", 64'({mem_req, d_ready}), 64'd0);
    step();
    check_eq("ld_mem_req", 64'(mem_req), 64'd1);
    check_eq("ld_mem_we", 64'(mem_we), 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 64'h1234;
    step();
    check_eq("ld_ready", 64'(d_ready), 64'd1);
    check_eq("ld_rdata", d_rdata, 64'h1234);
    check_eq("ld_err", 64'(d_err), 64'd0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    step();

    // Timeout: d_rdata is nonzero beforehand so the forced zero is visible
    d_req     = 1'b1;
    d_addr    = 64'h300;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cnt       = 0;
    seen      = 1'b0;
    err_s     = 1'b0;
    rdata_s   = '1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (d_ready) begin
        seen    = 1'b1;
        err_s   = d_err;
        rdata_s = d_rdata;
      end else if (mem_req) begin
        cnt++;
      end
    end
    check_eq("tmo_seen", 64'(seen), 64'd1);
    check_eq("tmo_len", 64'(cnt), 64'd16);
    check_eq("tmo_err", 64'(err_s), 64'd1);
    check_eq("tmo_rdata", rdata_s, 64'd0);
    d_req   = 1'b0;
    mem_ack = 1'b1;
    step();
    check_eq("tmo_late_ack", 64'({mem_req, d_ready, d_err}), 64'd0);
    mem_ack = 1'b0;
    step();
    check_eq("tmo_quiet", 64'({mem_req, d_ready, if_ready}), 64'd0);

    // Contention with immediate acks
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{"D", "I", "D", "I", "D", "I"};
`else
    exp_g = '{"D", "D", "D", "D", "I", "D"};
`endif
    got_g     = '{"-", "-", "-", "-", "-", "-"};
    if_addr   = 64'h8;
    d_addr    = 64'h200;
    d_we      = 1'b0;
    if_req    = 1'b1;
    d_req     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 64'h0;
    ng        = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      step();
      if (mem_req) begin
        got_g[ng] = (mem_addr == 64'h200) ? "D" : "I";
        ng++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("grant%0d", k), 64'(got_g[k]), 64'(exp_g[k]));
    end

    // Reset three cycles into BUSY
    do_reset();
    if_req  = 1'b1;
    if_addr = 64'h10;
    step();
    step();
    step();
    check_eq("rb_busy", 64'(mem_req), 64'd1);
    reset  = 1'b1;
    if_req = 1'b0;
    step();
    check_eq("rb_mem_req", 64'(mem_req), 64'd0);
    check_eq("rb_no_ready", 64'({if_ready, d_ready}), 64'd0);
    reset = 1'b0;
    step();
    check_eq("rb_idle", 64'({mem_req, if_ready, d_ready}), 64'd0);
    if_req = 1'b1;
    step();
    check_eq("rb_fresh_req", 64'(mem_req), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 64'h11111111_22222222;
    step();
    check_eq("rb_fresh_ready", 64'(if_ready), 64'd1);
    check_eq("rb_fresh_rdata", 64'(if_rdata), 64'h22222222);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    step();

    // Wait states: ack delayed five cycles
    if_req    = 1'b1;
    if_addr   = 64'h24;
    mem_rdata = 64'hCAFEF00D_12345678;
    rdy_at    = 0;
    stable    = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (if_ready && rdy_at == 0) rdy_at = i;
      if (i <= 6 && !(mem_req && mem_addr == 64'h24)) stable = 1'b0;
      if (i == 6) mem_ack = 1'b1;
      if (i == 7) begin
        mem_ack = 1'b0;
        if_req  = 1'b0;
      end
      if (i == 7) rdata_s = 64'(if_rdata);
    end
    check_eq("ws_addr_stable", 64'(stable), 64'd1);
    check_eq("ws_ready_at", 64'(rdy_at), 64'd7);
    check_eq("ws_rdata", rdata_s, 64'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (PC/instruction path) and the load/store requester (data path).
- Arbitrates between them, runs one memory transaction at a time, and returns read data with a one-cycle ready pulse.
- Aborts a transaction if the memory never acknowledges it.
- Sits between the CPU core and the backing memory model; it is the prerequisite for multi-cycle and stalling cores.

Parameters:
- ADDR_W, 64, address width for both requesters and the memory port
- TIMEOUT_CYCLES, 16, cycles spent in BUSY without mem_ack before abort; must be >= 2
- MAX_DATA_STREAK, 4, consecutive data grants allowed while if_req is pending; fixed-priority mode only

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  one-cycle pulse: fetch complete
- if_rdata  out  32  fetched instruction
- if_err  out  1  valid with if_ready: timeout abort
- d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  64  load data
- d_err  out  1  valid with d_ready: timeout abort
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only while mem_req = 1

Behaviour:
- FSM states: IDLE, BUSY, RESP. Owner register: 0 = fetch, 1 = data.
- Reset: state = IDLE. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_err, d_err, if_rdata, d_rdata. Timeout counter, streak counter and last-owner register are cleared.
- Reset mid-transaction: the transaction is dropped and no ready pulse is issued.
- IDLE:
  - Neither request pending: remain in IDLE.
  - Otherwise: pick a winner; register mem_addr/mem_we/mem_wdata from the winner; set mem_req = 1; go to BUSY.
  - A fetch grant drives mem_we = 0 and mem_wdata = 0.
- BUSY:
  - mem_req and all mem_* outputs are held constant.
  - mem_ack = 1: capture read data, drop mem_req, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop mem_req, set the winner's err, go to RESP. Read data is 0 in this case.
- RESP:
  - Exactly one of if_ready/d_ready is 1, for one cycle, with rdata and err valid. Then go to IDLE.
  - Requests are not sampled in RESP.
  - A req seen in the IDLE cycle after RESP is a new request, so back-to-back traffic is legal.
- Latency: req sampled at cycle N → mem_req at N+1 → ack at N+1 → ready at N+2. Minimum is 2 cycles; each extra ack wait cycle adds one.
- Fetch data select (address latched at grant): if_rdata = mem_rdata[63:32] when addr[2] = 1, else mem_rdata[31:0].
- d_rdata is all 64 bits of mem_rdata. Stores return d_rdata = mem_rdata as captured; callers ignore it.
- if_rdata/d_rdata hold their last value until the next RESP for that requester. err clears to 0 the cycle after RESP.
- Fixed-priority arbitration (default):
  - Data wins a tie.
  - Streak counter increments on each data grant made while if_req = 1.
  - Streak counter clears on any fetch grant, or on a data grant made with if_req = 0.
  - When streak = MAX_DATA_STREAK and both requests are pending, fetch wins.
- Requester protocol violations (req dropped, or address changed before ready): the arbiter's behaviour is undefined. The bench asserts against these.
- A late mem_ack arriving in RESP or IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, the requester that was not the last owner wins; the last owner updates on every grant. The streak counter and MAX_DATA_STREAK are not compiled in.
- Undefined: fixed data priority with the streak limit, as above.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x4; mem_ack at the first BUSY cycle with mem_rdata = 0xDEADBEEF_00A00093. Required: mem_req rises at +1, if_ready pulses at +2 with if_rdata = 0xDEADBEEF.
- Store/load: store (d_we = 1, addr 0x100, wdata 0x1234) then a load from 0x100. Required: mem_we = 1 for the first transaction, and d_ready pulses twice. For the load, mem_ack arrives with mem_rdata = 0x1234, and d_rdata = 0x1234.
- Contention, fixed priority: both requests held, ack always immediate. Required: grant order D, D, D, D, I, D. With MEM_ARB_ROUND_ROBIN_EN: D, I, D, I.
- Timeout: d_req, mem_ack never asserted. Required: mem_req stays high for 16 cycles, then d_ready = 1 with d_err = 1 and d_rdata = 0. mem_ack in the following cycle is ignored.
- Reset mid-BUSY: assert reset 3 cycles into BUSY. Required: the next cycle has mem_req = 0 and state IDLE, and no ready pulse occurs. A fresh request after reset completes normally.
- Wait states: fetch with mem_ack delayed 5 cycles. Required: mem_addr stable throughout, and if_ready exactly 7 cycles after the request is sampled.
